// File: rtl/pass_fail_monitor.sv
// Self-check stage: shadows one result register, detects a branch-to-self halt
// loop and raises exactly one sticky passed/failed verdict, with a cycle timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | program running; halt detection and timeout active
// ST_CHECK | halt seen; compare shadow against EXPECTED this cycle
// ST_PASS  | terminal pass verdict, held until reset
// ST_FAIL  | terminal fail verdict (wrong value or timeout), held until reset
module pass_fail_monitor #(
  parameter int          RESULT_REG = 10,
  parameter logic [31:0] EXPECTED   = 32'd45,
  parameter int          HALT_RUN   = 3,
  parameter int          TIMEOUT    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cyc_cnt,
  input  logic        rf_wr_en,
  input  logic [4:0]  rf_wr_index,
  input  logic [31:0] rf_wr_data,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  output logic        passed,
  output logic        failed
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CHECK = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam logic [4:0]  RESULT_IDX  = 5'(RESULT_REG);
  localparam logic [3:0]  HALT_CNT    = 4'(HALT_RUN);
  localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic        last_pc_vld_q, last_pc_vld_d;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic        passed_q, passed_d;
  logic        failed_q, failed_d;
  logic        halt;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    last_pc_d     = last_pc_q;
    last_pc_vld_d = last_pc_vld_q;
    run_cnt_d     = run_cnt_q;
    halt          = 1'b0;

    if (rf_wr_en && (rf_wr_index == RESULT_IDX)) begin
      shadow_d = rf_wr_data;
    end

    unique case (state_q)
      ST_RUN: begin
        if (instr_valid) begin
          last_pc_d     = pc;
          last_pc_vld_d = 1'b1;
          if (last_pc_vld_q && (pc == last_pc_q)) begin
            run_cnt_d = (run_cnt_q >= HALT_CNT) ? HALT_CNT : run_cnt_q + 4'd1;
          end else begin
            run_cnt_d = 4'd1;
          end
          halt = (run_cnt_d == HALT_CNT);
        end
        // Halt takes priority over a timeout landing on the same edge.
        if (halt) begin
          state_d = ST_CHECK;
        end else if (cyc_cnt >= TIMEOUT_CYC) begin
          state_d = ST_FAIL;
        end
      end
      ST_CHECK: begin
        state_d = (shadow_q == EXPECTED) ? ST_PASS : ST_FAIL;
      end
      ST_PASS: state_d = ST_PASS;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RUN;
    endcase

    passed_d = (state_d == ST_PASS);
    failed_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      shadow_q      <= 32'd0;
      last_pc_q     <= 32'd0;
      last_pc_vld_q <= 1'b0;
      run_cnt_q     <= 4'd0;
      passed_q      <= 1'b0;
      failed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      last_pc_q     <= last_pc_d;
      last_pc_vld_q <= last_pc_vld_d;
      run_cnt_q     <= run_cnt_d;
      passed_q      <= passed_d;
      failed_q      <= failed_d;
    end
  end

  assign passed = passed_q;
  assign failed = failed_q;

endmodule

// File: tb/tb_pass_fail_monitor.sv
// Bench for pass_fail_monitor: directed scenarios, a history-based reference
// model checked every cycle, and literal expectations at key points.
module tb_pass_fail_monitor;

  localparam int          RESULT_REG = 10;
  localparam logic [31:0] EXPECTED   = 32'd45;
  localparam int          HALT_RUN   = 3;
  localparam int          TIMEOUT    = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cyc_cnt;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_index;
  logic [31:0] rf_wr_data;
  logic        instr_valid;
  logic [31:0] pc;
  logic        passed;
  logic        failed;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  pass_fail_monitor #(
    .RESULT_REG(RESULT_REG), .EXPECTED(EXPECTED),
    .HALT_RUN(HALT_RUN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cyc_cnt(cyc_cnt),
    .rf_wr_en(rf_wr_en), .rf_wr_index(rf_wr_index), .rf_wr_data(rf_wr_data),
    .instr_valid(instr_valid), .pc(pc),
    .passed(passed), .failed(failed)
  );

  always #5 clk = ~clk;

  // Reference model: verdict 0 = none, 1 = pass, 2 = fail.
  logic [31:0] m_shadow;
  logic [31:0] m_check_val;
  bit          m_pending;
  int          m_verdict;
  logic [31:0] m_hist[$];

  always @(posedge clk) begin
    logic [31:0] new_shadow;
    bit          halted;
    if (reset) begin
      m_shadow  = 32'd0;
      m_pending = 0;
      m_verdict = 0;
      m_hist.delete();
    end else begin
      new_shadow = (rf_wr_en && rf_wr_index == 5'(RESULT_REG)) ? rf_wr_data : m_shadow;
      if (m_verdict == 0) begin
        if (m_pending) begin
          m_verdict = (m_check_val == EXPECTED) ? 1 : 2;
          m_pending = 0;
        end else begin
          halted = 0;
          if (instr_valid) begin
            m_hist.push_back(pc);
            if (m_hist.size() > HALT_RUN) void'(m_hist.pop_front());
            if (m_hist.size() == HALT_RUN) begin
              halted = 1;
              foreach (m_hist[i]) if (m_hist[i] != pc) halted = 0;
            end
          end
          if (halted) begin
            m_pending   = 1;
            m_check_val = new_shadow;
          end else if (cyc_cnt >= 32'(TIMEOUT)) begin
            m_verdict = 2;
          end
        end
      end
      m_shadow = new_shadow;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      tests++;
      if (passed !== (m_verdict == 1)) begin
        fails++;
        $display("FAIL model_passed t=%0t dut=%b model=%b", $time, passed, m_verdict == 1);
      end
      tests++;
      if (failed !== (m_verdict == 2)) begin
        fails++;
        $display("FAIL model_failed t=%0t dut=%b model=%b", $time, failed, m_verdict == 2);
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t dut=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the negedge, then return at the next negedge.
  task automatic step(input logic iv, input logic [31:0] p,
                      input logic we, input logic [4:0] wi, input logic [31:0] wd);
    instr_valid = iv;
    pc          = p;
    rf_wr_en    = we;
    rf_wr_index = wi;
    rf_wr_data  = wd;
    @(posedge clk);
    @(negedge clk);
    cyc_cnt = cyc_cnt + 32'd1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic retire(input logic [31:0] p);
    step(1'b1, p, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    step(1'b0, 32'd0, 1'b1, idx, d);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cyc_cnt = 32'd0;
    idle();
    reset   = 1'b0;
    cyc_cnt = 32'd1;
  endtask

  initial begin
    logic [31:0] c;
    reset = 1'b1; cyc_cnt = 32'd0;
    instr_valid = 1'b0; pc = 32'd0;
    rf_wr_en = 1'b0; rf_wr_index = 5'd0; rf_wr_data = 32'd0;

    // Pass case
    do_reset();
    started = 1;
    chk("reset_passed", passed, 1'b0);
    chk("reset_failed", failed, 1'b0);
    wr(5'd10, 32'd45);
    retire(32'h40); retire(32'h40); retire(32'h40);
    chk("pass_in_check", passed, 1'b0);
    idle();
    chk("pass_latency", passed, 1'b1);
    chk("pass_no_fail", failed, 1'b0);
    repeat (20) idle();
    chk("pass_sticky", passed, 1'b1);

    // Wrong value; a write to another register must not count
    do_reset();
    wr(5'd10, 32'd44);
    wr(5'd11, 32'd45);
    retire(32'h40); retire(32'h40); retire(32'h40);
    chk("wrong_in_check", failed, 1'b0);
    idle();
    chk("wrong_failed", failed, 1'b1);
    chk("wrong_passed", passed, 1'b0);

    // Bubbles and broken runs
    do_reset();
    wr(5'd10, 32'd45);
    retire(32'h40); idle(); retire(32'h40); idle(); retire(32'h44); idle();
    retire(32'h40); idle(); idle(); retire(32'h40);
    repeat (4) idle();
    chk("broken_no_pass", passed, 1'b0);
    chk("broken_no_fail", failed, 1'b0);
    retire(32'h40);
    idle();
    chk("bubble_run_pass", passed, 1'b1);

    // Timeout with changing PCs
    do_reset();
    while (cyc_cnt <= 32'd1000) begin
      c = cyc_cnt;
      retire(c << 2);
      if (c == 32'd999) chk("timeout_early", failed, 1'b0);
    end
    chk("timeout_failed", failed, 1'b1);
    chk("timeout_no_pass", passed, 1'b0);
    repeat (3) idle();

    // Halt on the same cycle as the timeout: halt wins
    do_reset();
    wr(5'd10, 32'd45);
    while (cyc_cnt < 32'd998) idle();
    retire(32'h80); retire(32'h80); retire(32'h80);
    chk("tie_no_fail", failed, 1'b0);
    idle();
    chk("tie_pass", passed, 1'b1);
    chk("tie_no_fail2", failed, 1'b0);

    // Write during CHECK does not affect the verdict, then reset mid-operation
    do_reset();
    wr(5'd10, 32'd45);
    retire(32'h40); retire(32'h40); retire(32'h40);
    wr(5'd10, 32'd0);
    chk("check_write_pass", passed, 1'b1);
    do_reset();
    chk("rst_clr_passed", passed, 1'b0);
    chk("rst_clr_failed", failed, 1'b0);
    retire(32'h40); retire(32'h40); retire(32'h40);
    idle();
    chk("rst_shadow_zero_fail", failed, 1'b1);

    // Write on the same edge that enters CHECK is used
    do_reset();
    wr(5'd10, 32'd44);
    retire(32'h60); retire(32'h60);
    step(1'b1, 32'h60, 1'b1, 5'd10, 32'd45);
    idle();
    chk("same_edge_write_pass", passed, 1'b1);
    repeat (2) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pass_fail_monitor.md
# pass_fail_monitor

Self-check stage inside `top` that produces the `passed`/`failed` pair consumed by the simulation testbench. It watches the CPU register-file write port and instruction-retire stream, keeps a shadow copy of one designated result register, and detects program completion as a branch-to-self halt loop. At halt it compares the shadow value against an expected constant and asserts exactly one sticky verdict. A cycle-count timeout forces a failure if the program never halts.

## Interface
Parameters:
- `RESULT_REG`, 10: register index checked at halt (x10/a0); legal range 1..31.
- `EXPECTED`, 32'd45: required final value of `RESULT_REG`.
- `HALT_RUN`, 3: number of consecutive valid instructions at an identical PC that signals halt; legal range 2..15.
- `TIMEOUT`, 1000: cycle count at which a still-running program fails.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cyc_cnt`  in  32  testbench cycle counter. It is 1 in the first cycle after reset and increments by 1 each cycle.
- `rf_wr_en`  in  1  register-file write strobe.
- `rf_wr_index`  in  5  register-file write index.
- `rf_wr_data`  in  32  register-file write data.
- `instr_valid`  in  1  an instruction retires this cycle.
- `pc`  in  32  PC of the retiring instruction; meaningful only when `instr_valid` = 1.
- `passed`  out  1  registered, sticky pass verdict.
- `failed`  out  1  registered, sticky fail verdict.

## Operation
- **Reset values:**
  - state = RUN; `passed` = 0, `failed` = 0.
  - shadow = 0; last_pc = 0; last_pc_vld = 0; run_cnt = 0.
- **Shadow register:** on `rf_wr_en` && `rf_wr_index` == `RESULT_REG`, shadow <= `rf_wr_data`. The update applies in every state. Writes to other indices are ignored.
- **Halt detection:** active in RUN only.
  - On `instr_valid`:
    - if last_pc_vld && `pc` == last_pc, then run_cnt <= run_cnt + 1 (saturating at `HALT_RUN`);
    - otherwise run_cnt <= 1.
    - In both cases, last_pc <= `pc` and last_pc_vld <= 1.
  - Cycles without `instr_valid` leave run_cnt and last_pc unchanged. Bubbles do not break a run.
  - Halt condition: the run_cnt update written this cycle equals `HALT_RUN`.
- **States:**
  - RUN -> CHECK when the halt condition occurs.
  - RUN -> FAIL when `cyc_cnt` >= `TIMEOUT` and there is no halt condition in the same cycle. If both occur together, halt wins.
  - CHECK -> PASS if shadow == `EXPECTED`, else CHECK -> FAIL. CHECK always resolves in exactly one cycle, and timeout is not evaluated in CHECK.
  - The comparison uses the shadow value registered at the start of CHECK. A result-register write arriving during the CHECK cycle updates shadow but does not affect the verdict.
  - PASS and FAIL are terminal until `reset`.
- **Outputs:**
  - `passed` = (state == PASS), driven from a flop.
  - `failed` = (state == FAIL), driven from a flop.
  - Never both 1. Once set, an output holds until `reset`.
- **Reset mid-operation:** all state returns to the reset values on the next edge, including clearing a verdict that was already asserted.

## Timing
- Latency from halt to verdict: if the halt condition occurs at edge N (state enters CHECK), `passed`/`failed` are high in the cycle after edge N+1.
- Timeout: `failed` rises in the cycle after the edge at which `cyc_cnt` = `TIMEOUT` is sampled in RUN.
- A shadow write at edge N is visible to a CHECK that begins at edge N or later. A write at the same edge that enters CHECK counts.
- No combinational path from any input to `passed` or `failed`.

## Test plan
- **Pass:** write x10 = 45, then retire pc = 0x40 three times consecutively, with no bubbles and `cyc_cnt` < 1000. Required: `passed` = 1 exactly 2 cycles after the third retire edge, `failed` = 0, and `passed` stays high for 20 further cycles.
- **Wrong value:** write x10 = 44, then halt at pc = 0x40. Required: `failed` = 1, `passed` = 0, same latency as the pass case.
- **Bubbles and broken runs:**
  - pc sequence 0x40, 0x40, 0x44, 0x40, 0x40, with idle cycles inserted between retires: no verdict.
  - A further 0x40 retire completes the run and produces the verdict.
- **Timeout:** instructions keep retiring at changing PCs. Required: `failed` rises the cycle after `cyc_cnt` = 1000 is sampled, and `passed` never rises.
- **Boundary cases:**
  - Halt condition in the same cycle as `cyc_cnt` = 1000, with x10 = 45: `passed` = 1, because halt wins.
  - A write x10 = 0 during the CHECK cycle: the verdict is still pass.
- **Reset mid-operation:**
  - Assert `reset` for 1 cycle after a `passed` verdict: both outputs become 0 and shadow becomes 0.
  - A subsequent halt without any x10 write: `failed` = 1 when `EXPECTED` = 45.
